// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// riscv_mem_arbiter : fetch/data arbiter for one single-port unified memory.
// Optional RISCV_MEMARB_RR_EN selects round-robin instead of data priority.
// Revision: 1.0
// ============================================================================
module riscv_mem_arbiter #(
  parameter int WIDTH   = 64,
  parameter int MEM_LAT = 2
) (
  input  logic             i_riscv_memarb_clk,
  input  logic             i_riscv_memarb_rst,
  input  logic             i_riscv_memarb_if_req,
  input  logic [WIDTH-1:0] i_riscv_memarb_if_addr,
  output logic [31:0]      o_riscv_memarb_if_inst,
  output logic             o_riscv_memarb_if_valid,
  input  logic             i_riscv_memarb_dm_req,
  input  logic             i_riscv_memarb_dm_we,
  input  logic [1:0]       i_riscv_memarb_dm_size,
  input  logic [WIDTH-1:0] i_riscv_memarb_dm_addr,
  input  logic [WIDTH-1:0] i_riscv_memarb_dm_wdata,
  output logic [WIDTH-1:0] o_riscv_memarb_dm_rdata,
  output logic             o_riscv_memarb_dm_valid,
  output logic             o_riscv_memarb_stall_f,
  output logic             o_riscv_memarb_stall_m,
  output logic             o_riscv_memarb_mem_en,
  output logic             o_riscv_memarb_mem_we,
  output logic [1:0]       o_riscv_memarb_mem_size,
  output logic [WIDTH-1:0] o_riscv_memarb_mem_addr,
  output logic [WIDTH-1:0] o_riscv_memarb_mem_wdata,
  input  logic [WIDTH-1:0] i_riscv_memarb_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             issue;
  logic             grant_data;
  logic [3:0]       lat_cnt;
  logic             owner;
  logic             owner_store;
  logic             owner_word_hi;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [1:0]       size_q;
  logic [WIDTH-1:0] issue_addr;
  logic [WIDTH-1:0] issue_wdata;
  logic [1:0]       issue_size;
  logic [31:0]      if_inst_q;
  logic [WIDTH-1:0] dm_rdata_q;
  logic             if_valid_q;
  logic             dm_valid_q;
  logic             unused_addr_bits;

  // Instruction fetches are word aligned; the byte offset carries no information.
  assign unused_addr_bits = ^i_riscv_memarb_if_addr[1:0];

`ifdef RISCV_MEMARB_RR_EN
  logic rr_prio_data;

  always_comb begin
    grant_data = i_riscv_memarb_dm_req & (~i_riscv_memarb_if_req | rr_prio_data);
  end

  // Priority passes to whichever requester was not granted this time.
  always_ff @(posedge i_riscv_memarb_clk or negedge i_riscv_memarb_rst) begin
    if (!i_riscv_memarb_rst) begin
      rr_prio_data <= 1'b1;
    end else if (issue) begin
      rr_prio_data <= ~grant_data;
    end
  end
`else
  always_comb begin
    grant_data = i_riscv_memarb_dm_req;
  end
`endif

  always_ff @(posedge i_riscv_memarb_clk or negedge i_riscv_memarb_rst) begin
    if (!i_riscv_memarb_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_riscv_memarb_if_req | i_riscv_memarb_dm_req) begin
          issue      = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_cnt == 4'd0) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    issue_addr  = grant_data ? i_riscv_memarb_dm_addr
                             : {i_riscv_memarb_if_addr[WIDTH-1:3], 3'b000};
    issue_size  = grant_data ? i_riscv_memarb_dm_size : 2'b11;
    issue_wdata = grant_data ? i_riscv_memarb_dm_wdata : wdata_q;
  end

  // The issue cycle drives the memory directly; afterwards the last values are held.
  always_ff @(posedge i_riscv_memarb_clk or negedge i_riscv_memarb_rst) begin
    if (!i_riscv_memarb_rst) begin
      lat_cnt       <= 4'd0;
      owner         <= 1'b0;
      owner_store   <= 1'b0;
      owner_word_hi <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      size_q        <= 2'b00;
      if_inst_q     <= 32'd0;
      dm_rdata_q    <= '0;
      if_valid_q    <= 1'b0;
      dm_valid_q    <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if (issue) begin
        owner         <= grant_data;
        owner_store   <= grant_data & i_riscv_memarb_dm_we;
        owner_word_hi <= i_riscv_memarb_if_addr[2];
        lat_cnt       <= 4'(MEM_LAT - 1);
        addr_q        <= issue_addr;
        size_q        <= issue_size;
        wdata_q       <= issue_wdata;
      end else if (state == S_WAIT) begin
        if (lat_cnt == 4'd0) begin
          if (owner) begin
            dm_valid_q <= 1'b1;
            if (!owner_store) begin
              dm_rdata_q <= i_riscv_memarb_mem_rdata;
            end
          end else begin
            if_valid_q <= 1'b1;
            if_inst_q  <= owner_word_hi ? i_riscv_memarb_mem_rdata[63:32]
                                        : i_riscv_memarb_mem_rdata[31:0];
          end
        end else begin
          lat_cnt <= lat_cnt - 4'd1;
        end
      end
    end
  end

  assign o_riscv_memarb_mem_en    = issue;
  assign o_riscv_memarb_mem_we    = issue & grant_data & i_riscv_memarb_dm_we;
  assign o_riscv_memarb_mem_addr  = issue ? issue_addr : addr_q;
  assign o_riscv_memarb_mem_size  = issue ? issue_size : size_q;
  assign o_riscv_memarb_mem_wdata = issue ? issue_wdata : wdata_q;

  assign o_riscv_memarb_if_inst   = if_inst_q;
  assign o_riscv_memarb_if_valid  = if_valid_q;
  assign o_riscv_memarb_dm_rdata  = dm_rdata_q;
  assign o_riscv_memarb_dm_valid  = dm_valid_q;
  assign o_riscv_memarb_stall_f   = i_riscv_memarb_if_req & ~if_valid_q;
  assign o_riscv_memarb_stall_m   = i_riscv_memarb_dm_req & ~dm_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_riscv_mem_arbiter : directed testbench for riscv_mem_arbiter (MEM_LAT=2).
// Revision: 1.0
// ============================================================================
module tb_riscv_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [1:0]  dm_size;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [63:0] dm_rdata;
  logic        dm_valid;
  logic        stall_f;
  logic        stall_m;
  logic        mem_en;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  riscv_mem_arbiter #(.WIDTH(64), .MEM_LAT(2)) dut (
    .i_riscv_memarb_clk       (clk),
    .i_riscv_memarb_rst       (rst_n),
    .i_riscv_memarb_if_req    (if_req),
    .i_riscv_memarb_if_addr   (if_addr),
    .o_riscv_memarb_if_inst   (if_inst),
    .o_riscv_memarb_if_valid  (if_valid),
    .i_riscv_memarb_dm_req    (dm_req),
    .i_riscv_memarb_dm_we     (dm_we),
    .i_riscv_memarb_dm_size   (dm_size),
    .i_riscv_memarb_dm_addr   (dm_addr),
    .i_riscv_memarb_dm_wdata  (dm_wdata),
    .o_riscv_memarb_dm_rdata  (dm_rdata),
    .o_riscv_memarb_dm_valid  (dm_valid),
    .o_riscv_memarb_stall_f   (stall_f),
    .o_riscv_memarb_stall_m   (stall_m),
    .o_riscv_memarb_mem_en    (mem_en),
    .o_riscv_memarb_mem_we    (mem_we),
    .o_riscv_memarb_mem_size  (mem_size),
    .o_riscv_memarb_mem_addr  (mem_addr),
    .o_riscv_memarb_mem_wdata (mem_wdata),
    .i_riscv_memarb_mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic exp_grant [4];
  logic got_grant [4];
  int   gcnt;
  logic exp_vf;
  logic exp_vm;

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_size = 2'b00; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    gcnt = 0;
    for (int k = 0; k < 4; k++) got_grant[k] = 1'b0;
`ifdef RISCV_MEMARB_RR_EN
    exp_grant[0] = 1'b1; exp_grant[1] = 1'b0; exp_grant[2] = 1'b1; exp_grant[3] = 1'b0;
`else
    exp_grant[0] = 1'b1; exp_grant[1] = 1'b1; exp_grant[2] = 1'b1; exp_grant[3] = 1'b1;
`endif

    // Reset state
    tick(); tick(); #1;
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_dm_valid", 64'(dm_valid), 64'd0);
    check("rst_if_inst", 64'(if_inst), 64'd0);
    check("rst_dm_rdata", dm_rdata, 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    rst_n = 1'b1;

    // Single fetch, upper word
    tick(); if_req = 1'b1; if_addr = 64'h104; mem_rdata = 64'hAAAA_BBBB_1111_2222; #1;
    check("f1_mem_en", 64'(mem_en), 64'd1);
    check("f1_mem_addr", mem_addr, 64'h100);
    check("f1_mem_size", 64'(mem_size), 64'd3);
    check("f1_mem_we", 64'(mem_we), 64'd0);
    check("f1_stall_f", 64'(stall_f), 64'd1);
    tick(); #1;
    check("f1_c1_mem_en", 64'(mem_en), 64'd0);
    check("f1_c1_addr_hold", mem_addr, 64'h100);
    check("f1_c1_if_valid", 64'(if_valid), 64'd0);
    tick(); #1;
    check("f1_c2_if_valid", 64'(if_valid), 64'd0);
    tick(); #1;
    check("f1_c3_if_valid", 64'(if_valid), 64'd1);
    check("f1_c3_if_inst", 64'(if_inst), 64'hAAAA_BBBB);
    check("f1_c3_stall_f", 64'(stall_f), 64'd0);
    if_req = 1'b0;

    // Simultaneous requests: data first, then fetch
    tick(); dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b11; dm_addr = 64'h2000;
    if_req = 1'b1; if_addr = 64'h20C; mem_rdata = 64'h1122_3344_5566_7788; #1;
    check("s_c0_mem_en", 64'(mem_en), 64'd1);
    check("s_c0_mem_addr", mem_addr, 64'h2000);
    check("s_c0_stall_m", 64'(stall_m), 64'd1);
    tick(); #1;
    tick(); #1;
    tick(); #1;
    check("s_c3_dm_valid", 64'(dm_valid), 64'd1);
    check("s_c3_dm_rdata", dm_rdata, 64'h1122_3344_5566_7788);
    check("s_c3_if_valid", 64'(if_valid), 64'd0);
    check("s_c3_stall_m", 64'(stall_m), 64'd0);
    check("s_c3_stall_f", 64'(stall_f), 64'd1);
    dm_req = 1'b0;
    tick(); mem_rdata = 64'hDEAD_BEEF_CAFE_F00D; #1;
    check("s_c4_mem_en", 64'(mem_en), 64'd1);
    check("s_c4_mem_addr", mem_addr, 64'h208);
    check("s_c4_mem_size", 64'(mem_size), 64'd3);
    tick(); #1;
    tick(); #1;
    tick(); #1;
    check("s_c7_if_valid", 64'(if_valid), 64'd1);
    check("s_c7_if_inst", 64'(if_inst), 64'hDEAD_BEEF);
    check("s_c7_dm_rdata_hold", dm_rdata, 64'h1122_3344_5566_7788);
    if_req = 1'b0;

    // Word store
    tick(); dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'b10; dm_addr = 64'h18;
    dm_wdata = 64'h55; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF; #1;
    check("st_c0_mem_en", 64'(mem_en), 64'd1);
    check("st_c0_mem_we", 64'(mem_we), 64'd1);
    check("st_c0_mem_size", 64'(mem_size), 64'd2);
    check("st_c0_mem_addr", mem_addr, 64'h18);
    check("st_c0_mem_wdata", mem_wdata, 64'h55);
    tick(); #1;
    check("st_c1_mem_en", 64'(mem_en), 64'd0);
    check("st_c1_mem_we", 64'(mem_we), 64'd0);
    check("st_c1_wdata_hold", mem_wdata, 64'h55);
    tick(); #1;
    tick(); #1;
    check("st_c3_dm_valid", 64'(dm_valid), 64'd1);
    check("st_c3_dm_rdata", dm_rdata, 64'h1122_3344_5566_7788);
    dm_req = 1'b0; dm_we = 1'b0;

    // Reset in the middle of a load
    tick(); dm_req = 1'b1; dm_size = 2'b11; dm_addr = 64'h40; #1;
    check("r_c0_mem_en", 64'(mem_en), 64'd1);
    tick(); rst_n = 1'b0; dm_req = 1'b0; #1;
    check("r_c1_mem_en", 64'(mem_en), 64'd0);
    check("r_c1_mem_addr", mem_addr, 64'd0);
    check("r_c1_dm_rdata", dm_rdata, 64'd0);
    check("r_c1_if_inst", 64'(if_inst), 64'd0);
    check("r_c1_stall_m", 64'(stall_m), 64'd0);
    tick(); #1;
    check("r_c2_dm_valid", 64'(dm_valid), 64'd0);
    tick(); #1;
    check("r_c3_dm_valid", 64'(dm_valid), 64'd0);
    tick(); rst_n = 1'b1; dm_req = 1'b1; dm_addr = 64'h48; mem_rdata = 64'h0F0F_0F0F_F0F0_F0F0; #1;
    check("r_rel_mem_en", 64'(mem_en), 64'd1);
    check("r_rel_mem_addr", mem_addr, 64'h48);
    tick(); #1;
    tick(); #1;
    tick(); #1;
    check("r_rel_dm_valid", 64'(dm_valid), 64'd1);
    check("r_rel_dm_rdata", dm_rdata, 64'h0F0F_0F0F_F0F0_F0F0);
    dm_req = 1'b0;

    // Fetch flushed during the wait; lower word selected
    tick(); if_req = 1'b1; if_addr = 64'h100; mem_rdata = 64'h0123_4567_89AB_CDEF; #1;
    check("fl_c0_mem_en", 64'(mem_en), 64'd1);
    tick(); if_req = 1'b0; #1;
    check("fl_c1_stall_f", 64'(stall_f), 64'd0);
    tick(); #1;
    tick(); #1;
    check("fl_c3_if_valid", 64'(if_valid), 64'd1);
    check("fl_c3_if_inst", 64'(if_inst), 64'h89AB_CDEF);
    check("fl_c3_stall_f", 64'(stall_f), 64'd0);

    // Both requesters held across four accesses
    tick(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h3000; if_req = 1'b1; if_addr = 64'h4000; #1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        tick(); #1;
      end
      exp_vf = ((i % 4) == 3) && !exp_grant[i / 4];
      exp_vm = ((i % 4) == 3) && exp_grant[i / 4];
      check($sformatf("rr_stall_f_%0d", i), 64'(stall_f), 64'(!exp_vf));
      check($sformatf("rr_stall_m_%0d", i), 64'(stall_m), 64'(!exp_vm));
      if (mem_en) begin
        if (gcnt < 4) got_grant[gcnt] = (mem_addr == 64'h3000);
        gcnt++;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    check("rr_grant_count", 64'(gcnt), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_grant_%0d", k), 64'(got_grant[k]), 64'(exp_grant[k]));
    end

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
